// File: rtl/hid_arb_pkg.sv
// Shared types and helpers for the HID report arbiter.
package hid_arb_pkg;

  localparam int HID_MAX_PORTS    = 4;
  localparam int HID_REPORT_BYTES = 8;
  localparam int HID_W            = HID_REPORT_BYTES * 8;
  localparam int HID_PORT_BITS    = 1;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } arb_state_e;

  // Round-robin pick: first pending port after 'last', wrapping at nports.
  // Returns {found, index}. Vectors are sized for the largest supported
  // port count; unused upper bits must be zero.
  function automatic logic [2:0] rr_next(input logic [HID_MAX_PORTS-1:0] pend,
                                         input logic [1:0] last,
                                         input int nports);
    logic [2:0] r;
    logic       found;
    int         idx;
    r     = '0;
    found = 1'b0;
    for (int i = 1; i <= HID_MAX_PORTS; i++) begin
      if (i <= nports && !found) begin
        idx = (int'(last) + i) % nports;
        if (pend[idx[1:0]]) begin
          found = 1'b1;
          r     = {1'b1, idx[1:0]};
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/hid_report_slot.sv
// One-entry holding slot for a single HID port: newest-wins capture,
// optional duplicate filtering against the last granted report, and
// saturating overwrite accounting.
module hid_report_slot #(
  parameter int W         = 64,
  parameter bit FILTER    = 1'b1,
  parameter int DROP_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  input  logic [W-1:0]         in_report_i,
  input  logic                 grant_i,
  output logic                 pending_o,
  output logic [W-1:0]         data_o,
  output logic                 drop_pulse_o,
  output logic [DROP_BITS-1:0] drop_count_o
);

  logic                 pending_q, pending_d;
  logic [W-1:0]         data_q;
  logic [W-1:0]         last_sent_q;
  logic                 seen_q;
  logic                 drop_pulse_q;
  logic [DROP_BITS-1:0] drop_count_q;

  logic is_dup, take, drop;

  // Filter against the pre-edge last_sent, so a same-cycle grant does not
  // influence whether the incoming report is a duplicate.
  always_comb begin
    is_dup    = FILTER && seen_q && (in_report_i == last_sent_q);
    take      = in_valid_i && !is_dup;
    drop      = take && pending_q && !grant_i;
    pending_d = pending_q;
    if (take)         pending_d = 1'b1;
    else if (grant_i) pending_d = 1'b0;
  end

  // Slot state, last-granted copy and drop accounting.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q    <= 1'b0;
      data_q       <= '0;
      last_sent_q  <= '0;
      seen_q       <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_count_q <= '0;
    end else begin
      pending_q    <= pending_d;
      drop_pulse_q <= drop;
      if (take) data_q <= in_report_i;
      if (grant_i) begin
        last_sent_q <= data_q;
        seen_q      <= 1'b1;
      end
      if (drop && !(&drop_count_q)) drop_count_q <= drop_count_q + 1'b1;
    end
  end

  assign pending_o    = pending_q;
  assign data_o       = data_q;
  assign drop_pulse_o = drop_pulse_q;
  assign drop_count_o = drop_count_q;

endmodule

// File: rtl/hid_report_arbiter.sv
// Round-robin arbiter sharing one report sink between several HID hosts.
// Each port has a holding slot; one report at a time is offered on a
// valid/ready interface and accepted reports land in a per-port display.
module hid_report_arbiter
  import hid_arb_pkg::*;
#(
  parameter int  C_ports        = 2,
  parameter int  C_report_bytes = HID_REPORT_BYTES,
  parameter int  C_filter_dup   = 1,
  parameter int  C_drop_bits    = 8,
  localparam int W              = C_report_bytes * 8,
  localparam int PORT_BITS      = (C_ports > 1) ? $clog2(C_ports) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [C_ports-1:0]             in_valid,
  input  logic [C_ports*W-1:0]           in_report,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PORT_BITS-1:0]           out_port,
  output logic [W-1:0]                   out_report,
  output logic [C_ports*W-1:0]           display,
  output logic [C_ports-1:0]             drop_pulse,
  output logic [C_ports*C_drop_bits-1:0] drop_count
);

  arb_state_e                  state_q, state_d;
  logic                        out_valid_q;
  logic [PORT_BITS-1:0]        out_port_q;
  logic [W-1:0]                out_report_q;
  logic [PORT_BITS-1:0]        last_grant_q;
  logic [C_ports-1:0][W-1:0]   display_q;

  logic [C_ports-1:0]          slot_pending;
  logic [C_ports-1:0][W-1:0]   slot_data;
  logic [C_ports-1:0]          grant;
  logic [HID_MAX_PORTS-1:0]    pend4;
  logic [2:0]                  nxt;
  logic [PORT_BITS-1:0]        gnt_port;

  for (genvar p = 0; p < C_ports; p++) begin : g_slot
    hid_report_slot #(
      .W         (W),
      .FILTER    (C_filter_dup != 0),
      .DROP_BITS (C_drop_bits)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .in_valid_i   (in_valid[p]),
      .in_report_i  (in_report[p*W +: W]),
      .grant_i      (grant[p]),
      .pending_o    (slot_pending[p]),
      .data_o       (slot_data[p]),
      .drop_pulse_o (drop_pulse[p]),
      .drop_count_o (drop_count[p*C_drop_bits +: C_drop_bits])
    );
  end

  // Pick the next pending port and decide the FSM transition.
  always_comb begin
    pend4                = '0;
    pend4[C_ports-1:0]   = slot_pending;
    nxt                  = rr_next(pend4, 2'(last_grant_q), C_ports);
    gnt_port             = PORT_BITS'(nxt[1:0]);
    for (int p = 0; p < C_ports; p++)
      grant[p] = (state_q == ST_IDLE) && nxt[2] && (nxt[1:0] == 2'(p));
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (nxt[2])    state_d = ST_OFFER;
      ST_OFFER: if (out_ready) state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Output offer registers, grant pointer and display capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      out_valid_q  <= 1'b0;
      out_port_q   <= '0;
      out_report_q <= '0;
      last_grant_q <= PORT_BITS'(C_ports - 1);
      display_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (nxt[2]) begin
            out_report_q <= slot_data[gnt_port];
            out_port_q   <= gnt_port;
            out_valid_q  <= 1'b1;
            last_grant_q <= gnt_port;
          end
        end
        ST_OFFER: begin
          if (out_ready) begin
            display_q[out_port_q] <= out_report_q;
            out_valid_q           <= 1'b0;
          end
        end
        default: out_valid_q <= 1'b0;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign out_port   = out_port_q;
  assign out_report = out_report_q;
  assign display    = display_q;

endmodule

// File: tb/tb_hid_report_arbiter.sv
// Directed bench for hid_report_arbiter (2 ports, 8-byte reports).
module tb_hid_report_arbiter;

  logic         clk;
  logic         rst;
  logic [1:0]   in_valid;
  logic [127:0] in_report;
  logic         out_valid;
  logic         out_ready;
  logic [0:0]   out_port;
  logic [63:0]  out_report;
  logic [127:0] display;
  logic [1:0]   drop_pulse;
  logic [15:0]  drop_count;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int dp0_cnt = 0;
  int dp1_cnt = 0;

  hid_report_arbiter #(
    .C_ports(2), .C_report_bytes(8), .C_filter_dup(1), .C_drop_bits(8)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_report(in_report),
    .out_valid(out_valid), .out_ready(out_ready), .out_port(out_port),
    .out_report(out_report), .display(display), .drop_pulse(drop_pulse),
    .drop_count(drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and drop-pulse counters sampled on the active edge.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) hs_cnt++;
    if (drop_pulse[0]) dp0_cnt++;
    if (drop_pulse[1]) dp1_cnt++;
  end

  typedef struct {
    logic         rst;
    logic [1:0]   iv;
    logic [63:0]  r0;
    logic [63:0]  r1;
    logic         rdy;
    logic         ov;
    logic         port;
    logic [63:0]  rep;
    logic [1:0]   dp;
    logic [127:0] disp;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  function automatic vec_t mk(logic r, logic [1:0] iv, logic [63:0] r0, logic [63:0] r1,
                              logic rdy, logic ov, logic port, logic [63:0] rep,
                              logic [1:0] dp, logic [63:0] d1, logic [63:0] d0);
    vec_t v;
    v.rst = r; v.iv = iv; v.r0 = r0; v.r1 = r1; v.rdy = rdy;
    v.ov = ov; v.port = port; v.rep = rep; v.dp = dp; v.disp = {d1, d0};
    return v;
  endfunction

  function automatic logic [63:0] A(int k); return 64'hAAAA_0000_0000_0000 | 64'(k); endfunction
  function automatic logic [63:0] B(int k); return 64'hBBBB_0000_0000_0000 | 64'(k); endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int port, input logic [63:0] val);
    in_valid            = '0;
    in_valid[port]      = 1'b1;
    in_report[port*64 +: 64] = val;
    tick();
    in_valid            = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  localparam logic [63:0] X1 = 64'h0102030405060708;

  initial begin
    int h0;
    int d0;
    int d1;
    rst = 1'b1; in_valid = '0; in_report = '0; out_ready = 1'b1;

    // rst iv     r0     r1     rdy | ov port rep    dp     disp1  disp0
    tbl[0]  = mk(1, 2'b00, 0,     0,     1,   0, 0,   0,     2'b00, 0,     0);
    tbl[1]  = mk(0, 2'b01, X1,    0,     1,   0, 0,   0,     2'b00, 0,     0);
    tbl[2]  = mk(0, 2'b00, 0,     0,     1,   1, 0,   X1,    2'b00, 0,     0);
    tbl[3]  = mk(0, 2'b00, 0,     0,     1,   0, 0,   X1,    2'b00, 0,     X1);
    tbl[4]  = mk(1, 2'b00, 0,     0,     1,   0, 0,   0,     2'b00, 0,     0);
    tbl[5]  = mk(0, 2'b11, A(0),  B(0),  1,   0, 0,   0,     2'b00, 0,     0);
    tbl[6]  = mk(0, 2'b11, A(1),  B(1),  1,   1, 0,   A(0),  2'b10, 0,     0);
    tbl[7]  = mk(0, 2'b11, A(2),  B(2),  1,   0, 0,   A(0),  2'b11, 0,     A(0));
    tbl[8]  = mk(0, 2'b11, A(3),  B(3),  1,   1, 1,   B(2),  2'b01, 0,     A(0));
    tbl[9]  = mk(0, 2'b11, A(4),  B(4),  1,   0, 1,   B(2),  2'b11, B(2),  A(0));
    tbl[10] = mk(0, 2'b11, A(5),  B(5),  1,   1, 0,   A(4),  2'b10, B(2),  A(0));
    tbl[11] = mk(0, 2'b00, 0,     0,     1,   0, 0,   A(4),  2'b00, B(2),  A(4));
    tbl[12] = mk(0, 2'b00, 0,     0,     1,   1, 1,   B(5),  2'b00, B(2),  A(4));
    tbl[13] = mk(0, 2'b00, 0,     0,     1,   0, 1,   B(5),  2'b00, B(5),  A(4));
    tbl[14] = mk(0, 2'b00, 0,     0,     1,   1, 0,   A(5),  2'b00, B(5),  A(4));
    tbl[15] = mk(0, 2'b00, 0,     0,     1,   0, 0,   A(5),  2'b00, B(5),  A(5));
    tbl[16] = mk(0, 2'b00, 0,     0,     1,   0, 0,   A(5),  2'b00, B(5),  A(5));

    // Single report, reset values, then round-robin under full load.
    for (int i = 0; i < NV; i++) begin
      rst = tbl[i].rst; in_valid = tbl[i].iv;
      in_report = {tbl[i].r1, tbl[i].r0}; out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("v%0d out_valid", i),  128'(out_valid),  128'(tbl[i].ov));
      chk($sformatf("v%0d out_port", i),   128'(out_port),   128'(tbl[i].port));
      chk($sformatf("v%0d out_report", i), 128'(out_report), 128'(tbl[i].rep));
      chk($sformatf("v%0d drop_pulse", i), 128'(drop_pulse), 128'(tbl[i].dp));
      chk($sformatf("v%0d display", i),    display,          tbl[i].disp);
      if (i == 3) chk("single drop_count", 128'(drop_count), 128'(0));
    end
    chk("rr drop_count", 128'(drop_count), 128'({8'd4, 8'd3}));
    in_valid = '0; rst = 1'b0;

    // Duplicate filtering.
    do_reset();
    out_ready = 1'b1;
    h0 = hs_cnt;
    pulse(1, 64'hDEAD_BEEF_0000_0001);
    repeat (10) tick();
    pulse(1, 64'hDEAD_BEEF_0000_0001);
    repeat (10) tick();
    chk("filter dup hs", 128'(hs_cnt - h0), 128'(1));
    chk("filter display1", display[127:64], 128'(64'hDEAD_BEEF_0000_0001));
    h0 = hs_cnt;
    pulse(0, 64'h0);
    repeat (10) tick();
    pulse(0, 64'h0);
    repeat (10) tick();
    chk("filter zero hs", 128'(hs_cnt - h0), 128'(1));
    chk("filter drop_count", 128'(drop_count), 128'(0));

    // Backpressure with newest-wins overwrite.
    do_reset();
    out_ready = 1'b0;
    h0 = hs_cnt; d0 = dp0_cnt;
    pulse(0, A(100));
    tick();
    chk("bp offer valid", 128'(out_valid), 128'(1));
    pulse(0, A(101));
    pulse(0, A(102));
    pulse(0, A(103));
    chk("bp held report", 128'(out_report), 128'(A(100)));
    chk("bp held valid", 128'(out_valid), 128'(1));
    chk("bp drop_count", 128'(drop_count[7:0]), 128'(2));
    tick();
    out_ready = 1'b1;
    repeat (6) tick();
    chk("bp hs", 128'(hs_cnt - h0), 128'(2));
    chk("bp display0", 128'(display[63:0]), 128'(A(103)));
    chk("bp drop pulses", 128'(dp0_cnt - d0), 128'(2));
    chk("bp idle", 128'(out_valid), 128'(0));

    // Same-cycle collision: new report arrives on the grant edge.
    do_reset();
    out_ready = 1'b0;
    h0 = hs_cnt; d1 = dp1_cnt;
    pulse(1, B(200));
    pulse(1, B(201));
    chk("col valid", 128'(out_valid), 128'(1));
    chk("col port", 128'(out_port), 128'(1));
    chk("col report", 128'(out_report), 128'(B(200)));
    chk("col drop_pulse", 128'(drop_pulse), 128'(0));
    out_ready = 1'b1;
    repeat (6) tick();
    chk("col hs", 128'(hs_cnt - h0), 128'(2));
    chk("col display1", display[127:64], 128'(B(201)));
    chk("col drop_count1", 128'(drop_count[15:8]), 128'(0));
    chk("col drop pulses", 128'(dp1_cnt - d1), 128'(0));

    // Reset while an offer is stalled.
    out_ready = 1'b0;
    pulse(0, A(300));
    tick();
    pulse(1, B(300));
    chk("rst pre valid", 128'(out_valid), 128'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst out_valid", 128'(out_valid), 128'(0));
    chk("rst display", display, 128'(0));
    chk("rst out_report", 128'(out_report), 128'(0));
    repeat (4) tick();
    chk("rst nothing pending", 128'(out_valid), 128'(0));
    out_ready = 1'b1;
    h0 = hs_cnt;
    pulse(0, A(300));
    repeat (4) tick();
    chk("rst refwd hs", 128'(hs_cnt - h0), 128'(1));
    chk("rst refwd display0", 128'(display[63:0]), 128'(A(300)));

    // Drop counter saturates instead of wrapping.
    do_reset();
    out_ready = 1'b0;
    pulse(0, A(400));
    tick();
    for (int i = 0; i < 300; i++) pulse(0, 64'(i + 1000));
    chk("sat drop_count0", 128'(drop_count[7:0]), 128'(255));
    chk("sat drop_count1", 128'(drop_count[15:8]), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
